// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the program counter, orders MIPS delay slots ahead of predicted
// redirects, parks on indirect jumps until the backend redirects, and owns the fetch->decode register.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,

  output logic [31:0] fetch_pc,
  output logic        fetch_req,
  input  logic        fetch_ready,

  input  logic        pd_is_branch,
  input  logic        pd_taken,
  input  logic [31:0] pd_target,
  input  logic        pd_indirect,

  input  logic        bk_redirect,
  input  logic [31:0] bk_target,

  input  logic        if_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        if_in_delay_slot,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDslot   = 2'd1,
    StWaitInd = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        ind_q, ind_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_ds_q, if_ds_d;
  logic        if_pt_q, if_pt_d;
  logic [31:0] if_ptgt_q, if_ptgt_d;

  logic        xfer;
  logic        pred_direct;
  logic [31:0] pc_plus4;

  assign fetch_req   = resetn & (state_q != StWaitInd);
  assign xfer        = fetch_req & fetch_ready & ~if_stall & ~bk_redirect;
  assign pc_plus4    = pc_q + 32'd4;
  // A predicted direct redirect is only honoured outside the delay slot.
  assign pred_direct = (state_q == StRun) & pd_is_branch & pd_taken & ~pd_indirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    ind_d      = ind_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_ds_d    = if_ds_q;
    if_pt_d    = if_pt_q;
    if_ptgt_d  = if_ptgt_q;

    if (bk_redirect) begin
      // Flush wins over decode backpressure; the word at fetch_pc this cycle is dropped.
      pc_d       = bk_target;
      state_d    = StRun;
      ind_d      = 1'b0;
      if_valid_d = 1'b0;
    end else if (xfer) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_ds_d    = (state_q == StDslot);
      if_pt_d    = pred_direct;
      if_ptgt_d  = pred_direct ? pd_target : 32'd0;

      unique case (state_q)
        StRun: begin
          pc_d = pc_plus4;
          if (pd_is_branch && pd_taken && !pd_indirect) begin
            tgt_d   = pd_target;
            ind_d   = 1'b0;
            state_d = StDslot;
          end else if (pd_is_branch && pd_indirect) begin
            ind_d   = 1'b1;
            state_d = StDslot;
          end
        end
        StDslot: begin
          if (ind_q) begin
            pc_d    = pc_plus4;
            state_d = StWaitInd;
          end else begin
            pc_d    = tgt_q;
            state_d = StRun;
          end
        end
        default: ;
      endcase
    end else if (!if_stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'd0;
      ind_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_ds_q    <= 1'b0;
      if_pt_q    <= 1'b0;
      if_ptgt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      ind_q      <= ind_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_ds_q    <= if_ds_d;
      if_pt_q    <= if_pt_d;
      if_ptgt_q  <= if_ptgt_d;
    end
  end

  assign fetch_pc         = pc_q;
  assign if_valid         = if_valid_q;
  assign if_pc            = if_pc_q;
  assign if_in_delay_slot = if_ds_q;
  assign if_pred_taken    = if_pt_q;
  assign if_pred_target   = if_ptgt_q;

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage sequencer that owns the program counter and drives instruction fetch, consuming the combinational branch prediction from the fetch-stage quick decoder. It enforces MIPS branch-delay-slot ordering: the slot is always fetched before a predicted redirect is applied. It stalls fetch on indirect jumps (JR/JALR), whose target is unknown at fetch, and applies backend misprediction redirects with highest priority. Sits between the I-cache fetch port and the fetch→decode pipeline register, which it also owns.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- fetch_pc  out  32  address presented to I-cache
- fetch_req  out  1  fetch request valid
- fetch_ready  in  1  instruction for fetch_pc available this cycle
- pd_is_branch  in  1  quick-decode: instruction at fetch_pc is a control transfer
- pd_taken  in  1  quick-decode: predicted taken
- pd_target  in  32  quick-decode: predicted target; valid when pd_taken and not pd_indirect
- pd_indirect  in  1  instruction is JR/JALR (target unknown)
- bk_redirect  in  1  backend misprediction/exception redirect
- bk_target  in  32  redirect address
- if_stall  in  1  decode cannot accept if_* this cycle
- if_valid  out  1  fetch→decode register holds an instruction
- if_pc  out  32  PC of that instruction
- if_in_delay_slot  out  1  instruction is a delay slot
- if_pred_taken  out  1  prediction applied to that instruction
- if_pred_target  out  32  target applied (0 if none)

## Operation
- xfer = fetch_req & fetch_ready & ~if_stall & ~bk_redirect.
- fetch_req = resetn & (state != WAIT_IND).
- State machine RUN / DSLOT / WAIT_IND. Internal regs: tgt (32), ind (1).
- RUN, xfer at PC P:
  - pd_is_branch & pd_taken & ~pd_indirect: tgt←pd_target, ind←0, →DSLOT, fetch_pc←P+4.
  - pd_is_branch & pd_indirect: ind←1, →DSLOT, fetch_pc←P+4.
  - otherwise: fetch_pc←P+4.
- DSLOT, xfer at PC P: if_in_delay_slot←1. Prediction inputs ignored.
  - If ind=0: fetch_pc←tgt, →RUN.
  - If ind=1: fetch_pc←P+4, →WAIT_IND.
- WAIT_IND: no fetch; exits only on bk_redirect.
- bk_redirect (any state, highest priority): fetch_pc←bk_target, →RUN, ind←0, if_valid←0 (flush, regardless of if_stall). The instruction at fetch_pc this cycle is discarded.
- if_* register:
  - On xfer: if_valid←1, if_pc←P, if_pred_taken←(RUN & pd_is_branch & pd_taken & ~pd_indirect), if_pred_target←pd_target if taken else 0.
  - if_stall & ~bk_redirect: hold all if_*.
  - ~if_stall & ~xfer & ~bk_redirect: if_valid←0.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC+4 = 0). Targets are passed unchanged; no alignment check (faults detected downstream).

## Timing
- Reset (resetn=0 at a clk edge): fetch_pc=RESET_PC, state=RUN, tgt=0, ind=0, if_valid=0, if_pc=0, if_in_delay_slot=0, if_pred_taken=0, if_pred_target=0. fetch_req=0 while resetn=0.
- Reset mid-operation overrides everything, including a pending bk_redirect or DSLOT.
- Fetch throughput: one instruction per cycle with fetch_ready=1 and no stall.
- Latency: fetch_pc to if_pc is 1 cycle. A taken branch costs no bubble; the delay slot fills it. bk_redirect to fetch_pc=bk_target is 1 cycle.
- fetch_ready=0: fetch_pc and state hold.
- if_stall=1: fetch_pc, state and if_* hold (unless bk_redirect).

## Test plan
- Sequential: reset release, fetch_ready=1, no branches → fetch_pc BFC00000, BFC00004, BFC00008 on consecutive cycles; if_pc follows one cycle later with if_valid=1.
- Taken branch at BFC00004 with pd_target=BFC00100 → fetch order BFC00000, 04, 08, BFC00100. if_* for 08 has if_in_delay_slot=1. if_* for 04 has if_pred_taken=1, if_pred_target=BFC00100.
- JR at 80000010 → fetch 80000014 (delay slot), then fetch_req=0 for 5 cycles. bk_redirect with bk_target=80002000 → next cycle fetch_pc=80002000, fetch_req=1.
- bk_redirect in DSLOT, same cycle as fetch_ready=1, with if_stall=1 → next cycle if_valid=0, state RUN, fetch_pc=bk_target; the saved tgt is never fetched.
- Backpressure: if_stall=1 for 3 cycles mid-stream → fetch_pc and if_* stable; stream resumes with no skipped or duplicated PC. fetch_ready=0 gaps similarly produce no skips.
- Wrap: bk_target=FFFFFFFC, non-branch → next fetch_pc=00000000; a mid-stream resetn=0 pulse → fetch_pc=BFC00000, if_valid=0.
